// File: rtl/usb_token_crc5_sequencer_pkg.sv
// usb_token_crc5_sequencer_pkg: shared state enum, field lengths and CRC5 defaults for the token sequencer
package usb_token_crc5_sequencer_pkg;
  typedef enum logic [1:0] {IDLE, SEND_PID, SEND_FIELD, SEND_CRC} state_e;
  localparam int PID_BITS = 8;
  localparam int FIELD_BITS = 11;
  localparam int CRC_BITS = 5;
  localparam logic [4:0] CRC_INIT_DEF = 5'b11111;
  localparam logic [4:0] CRC_POLY_DEF = 5'b00101;
  function automatic logic [4:0] crc5_step(input logic [4:0] crc, input logic din, input logic [4:0] poly);
    return {crc[3:0], 1'b0} ^ ((din ^ crc[4]) ? poly : 5'd0);
  endfunction
endpackage

// File: rtl/usb_token_crc5_sequencer_crc.sv
// usb_crc5_serial: bit-serial Galois CRC5 register, one data bit per shift
module usb_crc5_serial
  import usb_token_crc5_sequencer_pkg::*;
#(
  parameter logic [4:0] CRC_INIT = CRC_INIT_DEF,
  parameter logic [4:0] CRC_POLY = CRC_POLY_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       init,
  input  logic       shift,
  input  logic       din,
  output logic [4:0] crc
);
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) crc <= CRC_INIT;
    else if (init) crc <= CRC_INIT;
    else if (shift) crc <= crc5_step(crc, din, CRC_POLY);
  end
endmodule

// File: rtl/usb_token_crc5_sequencer.sv
// usb_token_crc5_sequencer: serialises a USB token (PID, ENDP/ADDR field, CRC5) one bit per bit_en strobe
module usb_token_crc5_sequencer
  import usb_token_crc5_sequencer_pkg::*;
#(
  parameter logic [4:0] CRC_INIT = CRC_INIT_DEF,
  parameter logic [4:0] CRC_POLY = CRC_POLY_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        tok_valid,
  output logic        tok_ready,
  input  logic [3:0]  tok_pid,
  input  logic [10:0] tok_field,
  input  logic        bit_en,
  input  logic        abort,
  output logic        tx_bit,
  output logic        tx_active,
  output logic        tx_done
);
  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [18:0] sh_q, sh_d;
  logic        bit_d, done_d, rdy_q;
  logic        accept, consume, last, crc_nx4;
  logic [4:0]  crc, crc_sh;
  assign tok_ready = rdy_q && state_q == IDLE && !abort;
  assign accept = tok_valid && tok_ready;
  assign consume = bit_en && state_q != IDLE;
  assign last = cnt_q == (state_q == SEND_PID ? 5'(PID_BITS - 1) :
                          state_q == SEND_FIELD ? 5'(FIELD_BITS - 1) : 5'(CRC_BITS - 1));
  // the first CRC bit must be registered on the same edge that absorbs the last field bit
  assign crc_nx4 = crc[3] ^ (CRC_POLY[4] & (crc[4] ^ sh_q[0]));
  assign crc_sh = crc << (cnt_q[2:0] + 3'd1);
  usb_crc5_serial #(.CRC_INIT(CRC_INIT), .CRC_POLY(CRC_POLY)) u_crc (
    .CLK(CLK),
    .RST(RST),
    .init(accept),
    .shift(consume && state_q == SEND_FIELD && !abort),
    .din(sh_q[0]),
    .crc(crc)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    bit_d = tx_bit;
    done_d = 1'b0;
    if (state_q != IDLE && abort) begin
      state_d = IDLE;
      cnt_d = '0;
      bit_d = 1'b0;
    end else if (accept) begin
      state_d = SEND_PID;
      cnt_d = '0;
      sh_d = {tok_field, ~tok_pid, tok_pid};
      bit_d = tok_pid[0];
    end else if (consume) begin
      cnt_d = last ? 5'd0 : cnt_q + 5'd1;
      sh_d = sh_q >> 1;
      state_d = !last ? state_q : state_q == SEND_PID ? SEND_FIELD : state_q == SEND_FIELD ? SEND_CRC : IDLE;
      bit_d = state_q == SEND_CRC ? (!last && !crc_sh[4]) : (state_q == SEND_FIELD && last) ? !crc_nx4 : sh_q[1];
      done_d = last && state_q == SEND_CRC;
    end
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sh_q <= '0;
      tx_bit <= 1'b0;
      tx_active <= 1'b0;
      tx_done <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      tx_bit <= bit_d;
      tx_active <= state_d != IDLE;
      tx_done <= done_d;
      rdy_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_usb_token_crc5_sequencer.sv
// tb_usb_token_crc5_sequencer: directed and randomised token checks against a polynomial-division reference
module tb_usb_token_crc5_sequencer;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        tok_valid = 1'b0;
  logic        tok_ready;
  logic [3:0]  tok_pid = '0;
  logic [10:0] tok_field = '0;
  logic        bit_en = 1'b0;
  logic        abort = 1'b0;
  logic        tx_bit, tx_active, tx_done;
  int checks = 0;
  int errors = 0;
  localparam logic [23:0] SETUP0 = {5'b00010, 11'b0, 8'b0010_1101};
  usb_token_crc5_sequencer dut (
    .CLK(CLK), .RST(RST), .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_pid(tok_pid), .tok_field(tok_field), .bit_en(bit_en), .abort(abort),
    .tx_bit(tx_bit), .tx_active(tx_active), .tx_done(tx_done)
  );
  always #5 CLK = ~CLK;
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  // wire order: PID byte LSB first, field LSB first, then complemented remainder MSB first
  function automatic logic [23:0] model(input logic [3:0] pid, input logic [10:0] fld);
    logic [15:0] v;
    logic [23:0] r;
    v = '0;
    for (int i = 0; i < 11; i++) v[15-i] = fld[i];
    v[15:11] = v[15:11] ^ 5'h1F;
    for (int d = 15; d >= 5; d--) if (v[d]) v = v ^ (16'h25 << (d - 5));
    r[7:0] = {~pid, pid};
    r[18:8] = fld;
    for (int k = 0; k < 5; k++) r[19+k] = ~v[4-k];
    return r;
  endfunction
  task automatic send(input logic [3:0] pid, input logic [10:0] fld, input int period,
                      input logic [23:0] exp, input int cut, input bit use_rst,
                      input bit hold, input logic [3:0] npid, input logic [10:0] nfld);
    tok_pid = pid;
    tok_field = fld;
    tok_valid = 1'b1;
    abort = 1'b0;
    #1;
    chk("ready_at_accept", tok_ready, 1);
    @(posedge CLK);
    #1;
    if (hold) begin
      tok_pid = npid;
      tok_field = nfld;
    end else begin
      tok_valid = 1'b0;
      tok_pid = 4'($urandom);
      tok_field = 11'($urandom);
    end
    for (int i = 0; i < 24; i++) begin
      for (int k = 0; k < period; k++) begin
        bit_en = (k == period - 1);
        chk("tx_active_busy", tx_active, 1);
        chk($sformatf("tx_bit_%0d", i), tx_bit, exp[i]);
        chk("tx_done_busy", tx_done, 0);
        if (i == cut && k == period - 1) begin
          if (use_rst) begin
            #2 RST = 1'b1;
            #1;
            chk("rst_tx_bit", tx_bit, 0);
            chk("rst_tx_active", tx_active, 0);
            chk("rst_tx_done", tx_done, 0);
            chk("rst_tok_ready", tok_ready, 0);
            #1 RST = 1'b0;
            tick();
            chk("ready_after_rst", tok_ready, 1);
            chk("active_after_rst", tx_active, 0);
          end else begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            #1;
            chk("abort_active", tx_active, 0);
            chk("abort_bit", tx_bit, 0);
            chk("abort_done", tx_done, 0);
          end
          return;
        end
        tick();
      end
    end
    chk("tx_done_pulse", tx_done, 1);
    chk("idle_active", tx_active, 0);
    chk("idle_bit", tx_bit, 0);
    chk("ready_in_done", tok_ready, 1);
  endtask
  initial begin
    logic [3:0] pa, pb;
    logic [10:0] fa, fb;
    #3;
    chk("reset_bit", tx_bit, 0);
    chk("reset_active", tx_active, 0);
    chk("reset_done", tx_done, 0);
    chk("reset_ready", tok_ready, 0);
    repeat (2) tick();
    chk("reset_ready_clocked", tok_ready, 0);
    RST = 1'b0;
    tick();
    chk("ready_after_release", tok_ready, 1);
    bit_en = 1'b1;
    tick();
    chk("idle_bit_en_active", tx_active, 0);
    send(4'hD, 11'd0, 1, SETUP0, -1, 0, 0, 4'h0, 11'h0);
    tick();
    chk("done_one_cycle", tx_done, 0);
    send(4'hD, 11'd0, 4, SETUP0, -1, 0, 0, 4'h0, 11'h0);
    tick();
    chk("done_one_cycle_slow", tx_done, 0);
    for (int n = 0; n < 200; n++) begin
      pa = 4'($urandom);
      fa = 11'($urandom);
      send(pa, fa, int'($urandom_range(1, 2)), model(pa, fa), -1, 0, 0, 4'h0, 11'h0);
    end
    tick();
    fa = 11'($urandom);
    send(4'hD, fa, 1, model(4'hD, fa), 12, 0, 0, 4'h0, 11'h0);
    repeat (3) begin
      tick();
      chk("no_done_after_abort", tx_done, 0);
    end
    send(4'hD, 11'd0, 1, SETUP0, -1, 0, 0, 4'h0, 11'h0);
    tick();
    abort = 1'b1;
    tok_valid = 1'b1;
    #1;
    chk("abort_blocks_ready", tok_ready, 0);
    tick();
    chk("abort_blocks_accept", tx_active, 0);
    abort = 1'b0;
    tok_valid = 1'b0;
    pa = 4'($urandom);
    fa = 11'($urandom);
    send(pa, fa, 1, model(pa, fa), 21, 1, 0, 4'h0, 11'h0);
    repeat (3) begin
      tick();
      chk("no_done_after_rst", tx_done, 0);
    end
    pa = 4'($urandom);
    fa = 11'($urandom);
    send(pa, fa, 1, model(pa, fa), -1, 0, 0, 4'h0, 11'h0);
    pa = 4'($urandom);
    fa = 11'($urandom);
    pb = ~pa;
    fb = ~fa;
    send(pa, fa, 1, model(pa, fa), -1, 0, 1, pb, fb);
    send(pb, fb, 2, model(pb, fb), -1, 0, 0, 4'h0, 11'h0);
    tick();
    chk("final_done_low", tx_done, 0);
    chk("final_active_low", tx_active, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/usb_token_crc5_sequencer.md
USB_TOKEN_CRC5_SEQUENCER -- requirements
Module: usb_token_crc5_sequencer

Interface
REQ-001 Parameter CRC_INIT, default 5'b11111: CRC5 register value loaded at the start of every token.
REQ-002 Parameter CRC_POLY, default 5'b00101: USB CRC5 generator polynomial x^5+x^2+1, with the x^5 term implicit.
REQ-003 CLK  in  1: single clock; all state updates on the rising edge.
REQ-004 RST  in  1: asynchronous, active-high reset.
REQ-005 tok_valid  in  1: a token request is present.
REQ-006 tok_ready  out  1: the block can accept a token this cycle.
REQ-007 tok_pid  in  4: PID nibble; the transmitted PID byte is {~tok_pid, tok_pid}.
REQ-008 tok_field  in  11: token field {ENDP[3:0], ADDR[6:0]}, sent LSB (ADDR[0]) first.
REQ-009 bit_en  in  1: bit-rate strobe; each high cycle consumes one output bit.
REQ-010 abort  in  1: cancel the current token.
REQ-011 tx_bit  out  1: current serial bit, NRZ, before any bit-stuffing.
REQ-012 tx_active  out  1: a token is being serialised.
REQ-013 tx_done  out  1: one-cycle pulse after the last CRC bit is consumed.

Function
REQ-014 The FSM SHALL have states IDLE, SEND_PID, SEND_FIELD and SEND_CRC, with a 5-bit bit counter.
- SEND_PID sends 8 bits; SEND_FIELD sends 11 bits; SEND_CRC sends 5 bits; 24 bits per token.
REQ-015 tok_ready SHALL be high only in IDLE with abort low; an accept is tok_valid && tok_ready.
REQ-016 On accept, the block SHALL:
- latch tok_pid and tok_field;
- load CRC_INIT into the CRC engine;
- enter SEND_PID next cycle with counter 0.
REQ-017 tx_bit SHALL be registered and stable between consumptions.
- A bit is consumed on a cycle where bit_en is high in a send state.
- The next bit appears on the following cycle.
REQ-018 SEND_PID SHALL output the PID byte LSB first, and SHALL NOT update the CRC engine.
REQ-019 SEND_FIELD SHALL output tok_field[0..10] in order; each consumed bit SHALL clock the CRC engine with that bit.
REQ-020 SEND_CRC SHALL output the ones-complement of the CRC register, CRC[4] first through CRC[0].
REQ-021 State transitions SHALL occur on consumption of the last bit of a state, with the counter cleared.
- After SEND_CRC the next state is IDLE, and tx_done pulses for one cycle in that IDLE cycle.
REQ-022 tx_active SHALL be high exactly in SEND_PID, SEND_FIELD and SEND_CRC; tx_bit SHALL be 0 in IDLE.
REQ-023 tok_valid while not in IDLE SHALL be ignored, and the latched token SHALL be unaffected.
REQ-024 Back-to-back tokens: tok_ready SHALL be high in the tx_done cycle, so the next accept can occur there.
REQ-025 abort high in any send state SHALL force IDLE on the next edge.
- No tx_done is produced.
- The CRC is reloaded at the next accept.
REQ-026 abort and tok_valid together in IDLE: abort SHALL win and no accept SHALL occur.
REQ-027 bit_en high in IDLE SHALL have no effect; bit_en may be high every cycle.

Reset
REQ-028 While RST is high, all of the following SHALL hold regardless of CLK:
- state=IDLE, counter=0, CRC=CRC_INIT;
- tx_bit=0, tx_active=0, tx_done=0, tok_ready=0.
REQ-029 On the first edge after RST deasserts, tok_ready SHALL be 1 when abort is low.
REQ-030 A reset asserted mid-token SHALL discard the token, and no tx_done SHALL follow.

Structure
REQ-031 A shared package SHALL hold the following, and nothing else module-local:
- the FSM state enum;
- the bit-length constants PID_BITS=8, FIELD_BITS=11, CRC_BITS=5;
- the CRC_INIT and CRC_POLY defaults.
REQ-032 The CRC SHALL be a sub-module, usb_crc5_serial, instantiated once.
- Ports: CLK, RST, init, shift, din, crc[4:0].
- Single-bit Galois update per shift.

Verification
REQ-033 SETUP, ADDR=0, ENDP=0 (tok_pid=4'hD, tok_field=0), bit_en always high:
- wire bits 1,0,1,1,0,1,0,0, then 11 zeros, then 0,1,0,0,0;
- tx_done pulses one cycle after the 24th bit.
REQ-034 The same token with bit_en high every 4th cycle: each bit held 4 cycles, identical sequence, tx_active high for 96 cycles.
REQ-035 Randomised PID and field, 200 tokens: the CRC bits SHALL match a bench CRC5 model (poly 0x05, init 0x1F, complemented, MSB first).
REQ-036 abort asserted on the 5th field bit:
- IDLE next cycle and no tx_done;
- a following token with tok_field=0 yields CRC wire bits 0,1,0,0,0.
REQ-037 RST pulsed asynchronously between edges during SEND_CRC:
- outputs go to 0 immediately;
- tok_ready=1 one edge after release;
- the next token is correct.
REQ-038 tok_valid held high for two tokens:
- the second token is accepted in the tx_done cycle;
- tok_valid during sending is ignored and the first token is unchanged.
